// File: rtl/td4_sw_conditioner_if.sv
// Switch-side bundle of the TD4 input conditioner: raw switches in and
// conditioned value, edge strobes and settled flag out.
interface td4_sw_conditioner_if;
  logic [3:0] sw_raw;
  logic [3:0] sw;
  logic [3:0] sw_rise;
  logic [3:0] sw_fall;
  logic       sw_valid;

  modport master (
    output sw_raw,
    input  sw,
    input  sw_rise,
    input  sw_fall,
    input  sw_valid
  );

  modport slave (
    input  sw_raw,
    output sw,
    output sw_rise,
    output sw_fall,
    output sw_valid
  );
endinterface

// File: rtl/td4_sw_conditioner.sv
// Synchronises and debounces the four TD4 board switches, producing a clean
// value, one-cycle edge strobes and a sticky settled flag.
module td4_sw_conditioner #(
  parameter int TICK_DIV   = 1000,
  parameter int STABLE_CNT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  td4_sw_conditioner_if.slave  swif
);

  localparam int PCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW  = $clog2(STABLE_CNT + 1);

  localparam logic [PCW-1:0] PC_LAST    = PCW'(TICK_DIV - 1);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(STABLE_CNT - 1);
  localparam logic [CW-1:0]  SETTLE_MAX = CW'(STABLE_CNT);

  logic [3:0]     s1_reg;
  logic [3:0]     s2_reg;
  logic [PCW-1:0] pc_reg;
  logic           tick;
  logic [CW-1:0]  settle_reg;
  logic           valid_reg;
  logic [3:0]     sw_vec;
  logic [3:0]     rise_vec;
  logic [3:0]     fall_vec;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_reg <= 4'b0000;
      s2_reg <= 4'b0000;
    end else begin
      s1_reg <= swif.sw_raw;
      s2_reg <= s1_reg;
    end
  end

  // With TICK_DIV=1 the counter never leaves 0, so tick stays high.
  assign tick = (pc_reg == PC_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_reg <= '0;
    end else if (tick) begin
      pc_reg <= '0;
    end else begin
      pc_reg <= pc_reg + 1'b1;
    end
  end

  // Valid rises on the same tick that would accept a switch held through reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      settle_reg <= '0;
      valid_reg  <= 1'b0;
    end else if (tick) begin
      if (settle_reg != SETTLE_MAX) begin
        settle_reg <= settle_reg + 1'b1;
      end
      if (settle_reg == CNT_LAST) begin
        valid_reg <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      logic [CW-1:0] cnt_reg;
      logic          bit_sw_reg;
      logic          bit_rise_reg;
      logic          bit_fall_reg;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          cnt_reg      <= '0;
          bit_sw_reg   <= 1'b0;
          bit_rise_reg <= 1'b0;
          bit_fall_reg <= 1'b0;
        end else begin
          bit_rise_reg <= 1'b0;
          bit_fall_reg <= 1'b0;
          if (tick) begin
            if (s2_reg[gi] == bit_sw_reg) begin
              cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
              cnt_reg      <= '0;
              bit_sw_reg   <= s2_reg[gi];
              bit_rise_reg <= s2_reg[gi];
              bit_fall_reg <= ~s2_reg[gi];
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
      end

      assign sw_vec[gi]   = bit_sw_reg;
      assign rise_vec[gi] = bit_rise_reg;
      assign fall_vec[gi] = bit_fall_reg;
    end
  endgenerate

  assign swif.sw       = sw_vec;
  assign swif.sw_rise  = rise_vec;
  assign swif.sw_fall  = fall_vec;
  assign swif.sw_valid = valid_reg;

endmodule

// File: tb/tb_td4_sw_conditioner.sv
// Directed bench for td4_sw_conditioner: a TICK_DIV=4/STABLE_CNT=3 instance
// and a TICK_DIV=1 instance, checked edge by edge against hand-derived values.
module tb_td4_sw_conditioner;

  logic clock = 1'b0;
  logic reset;
  int   e;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  td4_sw_conditioner_if if0 ();
  td4_sw_conditioner_if if1 ();

  td4_sw_conditioner #(.TICK_DIV(4), .STABLE_CNT(3)) dut0 (
    .clock (clock),
    .reset (reset),
    .swif  (if0.slave)
  );

  td4_sw_conditioner #(.TICK_DIV(1), .STABLE_CNT(3)) dut1 (
    .clock (clock),
    .reset (reset),
    .swif  (if1.slave)
  );

  task automatic step();
    @(posedge clock);
    #1;
    e++;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic [3:0] xsw, input logic [3:0] xrise,
                      input logic [3:0] xfall, input logic xvalid);
    check({tag, ".sw"},    if0.sw,               xsw);
    check({tag, ".rise"},  if0.sw_rise,          xrise);
    check({tag, ".fall"},  if0.sw_fall,          xfall);
    check({tag, ".valid"}, {3'b000, if0.sw_valid}, {3'b000, xvalid});
  endtask

  initial begin
    reset      = 1'b0;
    if0.sw_raw = 4'b0000;
    if1.sw_raw = 4'b0000;
    e          = 0;

    #50;
    chk0("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    check("reset.v1", {3'b000, if1.sw_valid}, 4'b0000);
    #50;
    reset = 1'b1;

    // Idle: valid rises on the 12th edge, the TICK_DIV=1 copy on the 3rd.
    while (e < 14) begin
      step();
      chk0("idle", 4'b0000, 4'b0000, 4'b0000, e >= 12);
      check("idle.v1", {3'b000, if1.sw_valid}, {3'b000, (e >= 3)});
    end

    // Clean step applied after edge 14: ticks at 20/24/28 see it, accept at 28.
    if0.sw_raw = 4'b0101;
    while (e < 30) begin
      step();
      chk0("step", (e >= 28) ? 4'b0101 : 4'b0000, (e == 28) ? 4'b0101 : 4'b0000, 4'b0000, 1'b1);
    end

    while (e < 44) begin
      if (e == 30) if0.sw_raw = 4'b0100;
      if (e == 36) if0.sw_raw = 4'b0101;
      step();
      chk0("glitch0", 4'b0101, 4'b0000, 4'b0000, 1'b1);
    end

    // Bit-2 glitch reaches two disagreeing ticks (48, 52) but not three.
    while (e < 58) begin
      if (e == 44) if0.sw_raw = 4'b0001;
      if (e == 50) if0.sw_raw = 4'b0101;
      step();
      chk0("glitch2", 4'b0101, 4'b0000, 4'b0000, 1'b1);
    end

    // Bit 3 toggles every 3 edges from 58, last toggle (to 1) at 88; accept at 100.
    while (e < 104) begin
      if (e >= 58 && e <= 88 && ((e - 58) % 3) == 0)
        if0.sw_raw[3] = ((((e - 58) / 3) % 2) == 0) ? 1'b1 : 1'b0;
      step();
      chk0("bounce", (e >= 100) ? 4'b1101 : 4'b0101, (e == 100) ? 4'b1000 : 4'b0000, 4'b0000, 1'b1);
    end

    while (e < 118) begin
      if (e == 104) if0.sw_raw = 4'b0010;
      step();
      chk0("multi", (e >= 116) ? 4'b0010 : 4'b1101, (e == 116) ? 4'b0010 : 4'b0000,
           (e == 116) ? 4'b1101 : 4'b0000, 1'b1);
    end

    if0.sw_raw = 4'b1111;
    while (e < 124) begin
      step();
      chk0("pre_rst", 4'b0010, 4'b0000, 4'b0000, 1'b1);
    end

    // Asynchronous reset mid-count, checked between clock edges.
    reset = 1'b0;
    #1;
    chk0("rst_async", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    check("rst_async.v1", {3'b000, if1.sw_valid}, 4'b0000);
    repeat (3) begin
      step();
      chk0("in_rst", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    reset = 1'b1;
    e     = 0;

    while (e < 14) begin
      step();
      chk0("rst_rel", (e >= 12) ? 4'b1111 : 4'b0000, (e == 12) ? 4'b1111 : 4'b0000, 4'b0000, e >= 12);
      check("rst_rel.v1", {3'b000, if1.sw_valid}, {3'b000, (e >= 3)});
    end

    // TICK_DIV=1: step sampled at edge 15, accepted at edge 19; 2-cycle glitch rejected.
    while (e < 30) begin
      if (e == 14) if1.sw_raw = 4'b0010;
      if (e == 21) if1.sw_raw = 4'b0000;
      if (e == 23) if1.sw_raw = 4'b0010;
      step();
      check("td1.sw",   if1.sw,      (e >= 19) ? 4'b0010 : 4'b0000);
      check("td1.rise", if1.sw_rise, (e == 19) ? 4'b0010 : 4'b0000);
      check("td1.fall", if1.sw_fall, 4'b0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
